// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU slice: bus enable codes, register
// offsets, opcodes and the FSM state encoding.
package alu_pkg;

   typedef enum logic [3:0] {
      EN_MAIN_MEM = 4'd0,
      EN_INST_MEM = 4'd1,
      EN_REG_FILE = 4'd2,
      EN_INT_ALU  = 4'd3,
      EN_FP_ALU   = 4'd4,
      EN_EXECUTE  = 4'd5
   } module_en_e;

   localparam logic [11:0] OFS_SRC1   = 12'd0;
   localparam logic [11:0] OFS_SRC2   = 12'd1;
   localparam logic [11:0] OFS_RESULT = 12'd2;
   localparam logic [11:0] OFS_CTRL   = 12'd3;

   localparam logic [7:0] OP_ADD = 8'h10;
   localparam logic [7:0] OP_SUB = 8'h11;
   localparam logic [7:0] OP_AND = 8'h12;
   localparam logic [7:0] OP_OR  = 8'h13;
   localparam logic [7:0] OP_MUL = 8'h14;
   localparam logic [7:0] OP_DIV = 8'h15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } md_mode_e;

endpackage

// File: rtl/integer_alu_if.sv
// Execution-engine register bus as seen by the integer ALU.
interface integer_alu_if;

   logic [15:0]  address;
   logic         nRead;
   logic         nWrite;
   logic [255:0] ExeDataOut;
   logic [255:0] IntDataOut;

   modport master (
      output address, nRead, nWrite, ExeDataOut,
      input  IntDataOut
   );

   modport slave (
      input  address, nRead, nWrite, ExeDataOut,
      output IntDataOut
   );

endinterface

// File: rtl/int_seq_muldiv.sv
// Iterative 32x32 unsigned multiplier / restoring divider, one step per cycle.
// done and result are valid combinationally during the final step cycle.
module int_seq_muldiv
   import alu_pkg::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic        Clk,
   input  logic        nReset,
   input  logic        start,
   input  md_mode_e    mode,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        done,
   output logic [63:0] result
);

   localparam int CNT_W = $clog2(MUL_CYCLES + 1);

   logic             run_q, run_d;
   md_mode_e         mode_q, mode_d;
   logic [31:0]      acc_q, acc_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      opnd_q, opnd_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [32:0] sum;
   logic [32:0] rem_shift;
   logic [32:0] diff;
   logic [31:0] step_acc;
   logic [31:0] step_lo;

   // acc holds the product high half (MUL) or the partial remainder (DIV);
   // lo holds the multiplier being shifted out or the dividend/quotient.
   always_comb begin
      sum       = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
      rem_shift = {acc_q, lo_q[31]};
      diff      = rem_shift - {1'b0, opnd_q};
      step_acc  = acc_q;
      step_lo   = lo_q;
      if (mode_q == MD_MUL) begin
         step_acc = sum[32:1];
         step_lo  = {sum[0], lo_q[31:1]};
      end else if (rem_shift >= {1'b0, opnd_q}) begin
         step_acc = diff[31:0];
         step_lo  = {lo_q[30:0], 1'b1};
      end else begin
         step_acc = rem_shift[31:0];
         step_lo  = {lo_q[30:0], 1'b0};
      end
   end

   assign done   = run_q && (count_q == CNT_W'(MUL_CYCLES - 1));
   assign result = {step_acc, step_lo};

   always_comb begin
      run_d   = run_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      opnd_d  = opnd_q;
      count_d = count_q;
      if (start) begin
         run_d   = 1'b1;
         mode_d  = mode;
         acc_d   = '0;
         count_d = '0;
         lo_d    = (mode == MD_MUL) ? op_b : op_a;
         opnd_d  = (mode == MD_MUL) ? op_a : op_b;
      end else if (run_q) begin
         acc_d   = step_acc;
         lo_d    = step_lo;
         count_d = count_q + CNT_W'(1);
         if (done) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         run_q   <= 1'b0;
         mode_q  <= MD_MUL;
         acc_q   <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         count_q <= '0;
      end else begin
         run_q   <= run_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/integer_alu.sv
// Memory-mapped 256-bit integer ALU: SRC1/SRC2/RESULT/OPCODE-STATUS registers,
// single-cycle logic/arith ops and iterative 32-bit multiply/divide.
module integer_alu
   import alu_pkg::*;
#(
   parameter logic [3:0] INT_ALU_EN = 4'd3,
   parameter int         MUL_CYCLES = 32
) (
   input  logic          Clk,
   input  logic          nReset,
   integer_alu_if.slave  bus
);

   alu_state_e   state_q, state_d;
   logic [255:0] src1_q, src1_d;
   logic [255:0] src2_q, src2_d;
   logic [255:0] result_q, result_d;
   logic [7:0]   opcode_q, opcode_d;
   logic         error_q, error_d;

   logic         sel;
   logic         wr_en;
   logic         rd_en;
   logic [11:0]  offset;
   logic         busy;
   logic         done;
   logic [255:0] rd_data;

   logic         md_start;
   md_mode_e     md_mode;
   logic         md_done;
   logic [63:0]  md_result;

   // Writes are dropped for the whole iterative operation, so the operands
   // captured by the sequencer at start cannot be disturbed.
   assign sel    = (bus.address[15:12] == INT_ALU_EN);
   assign offset = bus.address[11:0];
   assign wr_en  = sel && !bus.nWrite && (state_q != ITER);
   assign rd_en  = sel && !bus.nRead;

   int_seq_muldiv #(
      .MUL_CYCLES (MUL_CYCLES)
   ) u_muldiv (
      .Clk    (Clk),
      .nReset (nReset),
      .start  (md_start),
      .mode   (md_mode),
      .op_a   (src1_q[31:0]),
      .op_b   (src2_q[31:0]),
      .done   (md_done),
      .result (md_result)
   );

   always_comb begin
      src1_d   = src1_q;
      src2_d   = src2_q;
      result_d = result_q;
      opcode_d = opcode_q;
      error_d  = error_q;
      md_start = 1'b0;
      md_mode  = MD_MUL;
      if (wr_en) begin
         case (offset)
            OFS_SRC1: src1_d = bus.ExeDataOut;
            OFS_SRC2: src2_d = bus.ExeDataOut;
            OFS_CTRL: begin
               opcode_d = bus.ExeDataOut[7:0];
               error_d  = 1'b0;
               case (bus.ExeDataOut[7:0])
                  OP_ADD: result_d = src1_q + src2_q;
                  OP_SUB: result_d = src1_q - src2_q;
                  OP_AND: result_d = src1_q & src2_q;
                  OP_OR:  result_d = src1_q | src2_q;
                  OP_MUL: md_start = 1'b1;
                  OP_DIV: begin
                     if (src2_q[31:0] == 32'd0) begin
                        error_d  = 1'b1;
                        result_d = {192'd0, {64{1'b1}}};
                     end else begin
                        md_start = 1'b1;
                        md_mode  = MD_DIV;
                     end
                  end
                  default: begin
                     error_d  = 1'b1;
                     result_d = '0;
                  end
               endcase
            end
            default: ;
         endcase
      end
      if ((state_q == ITER) && md_done) begin
         result_d = {192'd0, md_result};
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (wr_en && (offset == OFS_CTRL)) begin
               state_d = md_start ? ITER : DONE;
            end
         end
         ITER: begin
            if (md_done) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read path is combinational, so a same-edge read returns the pre-edge value.
   always_comb begin
      busy    = (state_q == ITER);
      done    = (state_q == DONE);
      rd_data = '0;
      case (offset)
         OFS_SRC1:   rd_data = src1_q;
         OFS_SRC2:   rd_data = src2_q;
         OFS_RESULT: rd_data = result_q;
         OFS_CTRL:   rd_data = {253'd0, error_q, done, busy};
         default:    rd_data = '0;
      endcase
      bus.IntDataOut = (rd_en && nReset) ? rd_data : '0;
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q  <= IDLE;
         src1_q   <= '0;
         src2_q   <= '0;
         result_q <= '0;
         opcode_q <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         src1_q   <= src1_d;
         src2_q   <= src2_d;
         result_q <= result_d;
         opcode_q <= opcode_d;
         error_q  <= error_d;
      end
   end

endmodule

// File: tb/tb_integer_alu.sv
// Self-checking bench for integer_alu: directed vectors, bus corner cases,
// abort-by-reset and randomized operations against a behavioural model.
module tb_integer_alu;

   localparam logic [3:0]  EN      = 4'd3;
   localparam logic [11:0] R_SRC1  = 12'd0;
   localparam logic [11:0] R_SRC2  = 12'd1;
   localparam logic [11:0] R_RES   = 12'd2;
   localparam logic [11:0] R_CTRL  = 12'd3;
   localparam logic [255:0] ONES256 = {256{1'b1}};
   localparam logic [255:0] ONES64  = {192'd0, {64{1'b1}}};

   logic Clk = 1'b0;
   logic nReset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   integer_alu_if bus ();

   integer_alu #(
      .INT_ALU_EN (4'd3),
      .MUL_CYCLES (32)
   ) dut (
      .Clk    (Clk),
      .nReset (nReset),
      .bus    (bus)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference behaviour straight from the operation definitions.
   function automatic logic [255:0] ref_model(input logic [7:0] op, input logic [255:0] a,
                                              input logic [255:0] b, output logic err);
      logic [255:0] res;
      logic [63:0]  p;
      logic [31:0]  q;
      logic [31:0]  r;
      err = 1'b0;
      res = '0;
      case (op)
         8'h10: res = a + b;
         8'h11: res = a - b;
         8'h12: res = a & b;
         8'h13: res = a | b;
         8'h14: begin
            p   = {32'd0, a[31:0]} * {32'd0, b[31:0]};
            res = {192'd0, p};
         end
         8'h15: begin
            if (b[31:0] == 32'd0) begin
               err = 1'b1;
               res = ONES64;
            end else begin
               q   = a[31:0] / b[31:0];
               r   = a[31:0] % b[31:0];
               res = {192'd0, r, q};
            end
         end
         default: err = 1'b1;
      endcase
      return res;
   endfunction

   function automatic int ref_busy(input logic [7:0] op, input logic [255:0] b);
      if (op == 8'h14) return 32;
      if (op == 8'h15 && b[31:0] != 32'd0) return 32;
      return 0;
   endfunction

   // Called just after a negedge; the write lands on the following posedge.
   task automatic bus_write(input logic [3:0] en, input logic [11:0] ofs, input logic [255:0] data);
      bus.address    = {en, ofs};
      bus.ExeDataOut = data;
      bus.nWrite     = 1'b0;
      @(negedge Clk);
      bus.nWrite     = 1'b1;
   endtask

   task automatic bus_read(input logic [3:0] en, input logic [11:0] ofs, output logic [255:0] data);
      bus.address = {en, ofs};
      bus.nRead   = 1'b0;
      #1;
      data        = bus.IntDataOut;
      bus.nRead   = 1'b1;
   endtask

   task automatic wait_idle(output logic [255:0] stat, output int cycles);
      cycles = 0;
      bus_read(EN, R_CTRL, stat);
      while (stat[0] === 1'b1 && cycles < 200) begin
         @(negedge Clk);
         cycles++;
         bus_read(EN, R_CTRL, stat);
      end
   endtask

   task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [255:0] opw,
                         output logic [255:0] res, output logic [255:0] stat, output int cycles);
      bus_write(EN, R_SRC1, a);
      bus_write(EN, R_SRC2, b);
      bus_write(EN, R_CTRL, opw);
      wait_idle(stat, cycles);
      bus_read(EN, R_RES, res);
   endtask

   task automatic test_reset();
      logic [255:0] d;
      #3;
      for (int i = 0; i < 4; i++) begin
         bus_read(EN, 12'(i), d);
         checks++;
         if (d !== '0) begin
            errors++;
            $display("[TB] FAIL reset_read ofs=%0d got %h want 0", i, d);
         end
      end
      @(negedge Clk);
      bus_write(EN, R_SRC1, 256'hDEAD);
      nReset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus_read(EN, 12'(i), d);
         checks++;
         if (d !== '0) begin
            errors++;
            $display("[TB] FAIL post_reset ofs=%0d got %h want 0", i, d);
         end
      end
      bus.address = {EN, R_CTRL};
      #1;
      checks++;
      if (bus.IntDataOut !== '0) begin
         errors++;
         $display("[TB] FAIL no_read_strobe got %h want 0", bus.IntDataOut);
      end
      @(negedge Clk);
   endtask

   task automatic test_add();
      logic [255:0] res, stat;
      int cyc;
      run_op(256'd5, 256'd7, 256'h10, res, stat, cyc);
      checks++;
      if (stat !== 256'h2 || cyc != 0) begin
         errors++;
         $display("[TB] FAIL add_status got %h/%0d want 2/0", stat, cyc);
      end
      checks++;
      if (res !== 256'd12) begin
         errors++;
         $display("[TB] FAIL add_result got %h want 12", res);
      end
   endtask

   task automatic test_sub_wrap();
      logic [255:0] res, stat;
      int cyc;
      run_op(256'd0, 256'd1, 256'h11, res, stat, cyc);
      checks++;
      if (res !== ONES256 || stat !== 256'h2) begin
         errors++;
         $display("[TB] FAIL sub_wrap got %h stat %h want all ones stat 2", res, stat);
      end
   endtask

   task automatic test_mul_max();
      logic [255:0] res, stat;
      int cyc;
      run_op(256'hFFFFFFFF, 256'hFFFFFFFF, 256'h14, res, stat, cyc);
      checks++;
      if (cyc != 32) begin
         errors++;
         $display("[TB] FAIL mul_busy_cycles got %0d want 32", cyc);
      end
      checks++;
      if (res !== 256'hFFFFFFFE00000001 || stat !== 256'h2) begin
         errors++;
         $display("[TB] FAIL mul_max got %h stat %h want fffffffe00000001 stat 2", res, stat);
      end
   endtask

   task automatic test_div();
      logic [255:0] res, stat;
      int cyc;
      run_op(256'd100, 256'd7, 256'h15, res, stat, cyc);
      checks++;
      if (res[31:0] !== 32'd14 || res[63:32] !== 32'd2 || res[255:64] !== '0 || stat !== 256'h2) begin
         errors++;
         $display("[TB] FAIL div_100_7 got %h stat %h want q14 r2 stat 2", res, stat);
      end
      run_op(256'd100, 256'd0, 256'h15, res, stat, cyc);
      checks++;
      if (res !== ONES64 || stat !== 256'h6 || cyc != 0) begin
         errors++;
         $display("[TB] FAIL div_zero got %h stat %h cyc %0d want 64 ones stat 6 cyc 0", res, stat, cyc);
      end
   endtask

   task automatic test_select_and_map();
      logic [255:0] res, stat, d;
      int cyc;
      run_op(256'hAAAA, 256'h5555, 256'h13, res, stat, cyc);
      bus_write(4'd2, R_SRC1, 256'h1234);
      bus_write(4'd2, R_CTRL, 256'h10);
      bus_write(EN, R_RES, 256'h9999);
      bus_write(EN, 12'd5, 256'h7777);
      bus_read(EN, R_SRC1, d);
      checks++;
      if (d !== 256'hAAAA) begin
         errors++;
         $display("[TB] FAIL foreign_enable_write got %h want aaaa", d);
      end
      bus_read(EN, R_RES, d);
      checks++;
      if (d !== 256'hFFFF) begin
         errors++;
         $display("[TB] FAIL result_readonly got %h want ffff", d);
      end
      bus_read(4'd2, R_SRC1, d);
      checks++;
      if (d !== '0) begin
         errors++;
         $display("[TB] FAIL foreign_enable_read got %h want 0", d);
      end
      bus_read(EN, 12'd5, d);
      checks++;
      if (d !== '0) begin
         errors++;
         $display("[TB] FAIL unmapped_read got %h want 0", d);
      end
      bus_write(EN, R_CTRL, 256'h7F);
      wait_idle(stat, cyc);
      bus_read(EN, R_RES, res);
      checks++;
      if (stat !== 256'h6 || res !== '0) begin
         errors++;
         $display("[TB] FAIL bad_opcode got stat %h res %h want 6 and 0", stat, res);
      end
   endtask

   task automatic test_read_write_same_edge();
      logic [255:0] pre, post;
      bus_write(EN, R_SRC1, 256'h1111);
      bus.address    = {EN, R_SRC1};
      bus.ExeDataOut = 256'h2222;
      bus.nWrite     = 1'b0;
      bus.nRead      = 1'b0;
      #1;
      pre = bus.IntDataOut;
      @(posedge Clk);
      #1;
      post = bus.IntDataOut;
      @(negedge Clk);
      bus.nWrite = 1'b1;
      bus.nRead  = 1'b1;
      checks++;
      if (pre !== 256'h1111 || post !== 256'h2222) begin
         errors++;
         $display("[TB] FAIL rw_same_edge got pre %h post %h want 1111/2222", pre, post);
      end
   endtask

   task automatic test_busy_and_abort();
      logic [255:0] a, b, d, res, stat;
      int cyc;
      a = rand256();
      b = rand256();
      bus_write(EN, R_SRC1, a);
      bus_write(EN, R_SRC2, b);
      bus_write(EN, R_CTRL, 256'h14);
      repeat (4) @(negedge Clk);
      bus_write(EN, R_SRC1, 256'd9);
      bus_write(EN, R_CTRL, 256'h10);
      bus_write(EN, R_SRC2, 256'd3);
      bus_read(EN, R_SRC1, d);
      checks++;
      if (d !== a) begin
         errors++;
         $display("[TB] FAIL busy_write_src1 got %h want %h", d, a);
      end
      bus_read(EN, R_SRC2, d);
      bus_read(EN, R_CTRL, stat);
      checks++;
      if (d !== b || stat !== 256'h1) begin
         errors++;
         $display("[TB] FAIL busy_state src2 %h stat %h want %h stat 1", d, stat, b);
      end
      repeat (3) @(negedge Clk);
      #2 nReset = 1'b0;
      #1 nReset = 1'b1;
      @(negedge Clk);
      for (int i = 0; i < 4; i++) begin
         bus_read(EN, 12'(i), d);
         checks++;
         if (d !== '0) begin
            errors++;
            $display("[TB] FAIL abort_clear ofs=%0d got %h want 0", i, d);
         end
      end
      repeat (40) @(negedge Clk);
      bus_read(EN, R_RES, res);
      bus_read(EN, R_CTRL, stat);
      checks++;
      if (res !== '0 || stat !== '0) begin
         errors++;
         $display("[TB] FAIL abort_no_update res %h stat %h want 0/0", res, stat);
      end
      run_op(256'd3, 256'd4, 256'h10, res, stat, cyc);
      checks++;
      if (res !== 256'd7 || stat !== 256'h2) begin
         errors++;
         $display("[TB] FAIL add_after_abort res %h stat %h want 7 stat 2", res, stat);
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] a, b, exp, res, stat;
      logic [7:0] ops [4];
      logic err;
      int cyc;
      ops[0] = 8'h14; ops[1] = 8'h11; ops[2] = 8'h15; ops[3] = 8'h12;
      a = rand256();
      b = rand256();
      b[31:0] = 32'(1 + $urandom_range(0, 1000));
      bus_write(EN, R_SRC1, a);
      bus_write(EN, R_SRC2, b);
      for (int i = 0; i < 4; i++) begin
         bus_write(EN, R_CTRL, {248'd0, ops[i]});
         wait_idle(stat, cyc);
         bus_read(EN, R_RES, res);
         exp = ref_model(ops[i], a, b, err);
         checks++;
         if (res !== exp || stat !== 256'h2 || cyc != ref_busy(ops[i], b)) begin
            errors++;
            $display("[TB] FAIL back_to_back op %h got %h stat %h cyc %0d want %h", ops[i], res, stat, cyc, exp);
         end
      end
   endtask

   task automatic test_random_ops();
      logic [255:0] a, b, opw, exp, res, stat;
      logic [7:0] op;
      logic err;
      int cyc, sel;
      for (int n = 0; n < 30; n++) begin
         a   = rand256();
         b   = rand256();
         sel = $urandom_range(0, 6);
         op  = (sel == 6) ? 8'(8'h20 + $urandom_range(0, 200)) : 8'(8'h10 + sel);
         if (op == 8'h15 && $urandom_range(0, 3) == 0) b[31:0] = 32'd0;
         else if (op == 8'h15 && $urandom_range(0, 1) == 0) b[31:0] = 32'($urandom_range(1, 50));
         opw      = rand256();
         opw[7:0] = op;
         run_op(a, b, opw, res, stat, cyc);
         exp = ref_model(op, a, b, err);
         checks++;
         if (res !== exp) begin
            errors++;
            $display("[TB] FAIL random_result op %h got %h want %h", op, res, exp);
         end
         checks++;
         if (stat !== (err ? 256'h6 : 256'h2) || cyc != ref_busy(op, b)) begin
            errors++;
            $display("[TB] FAIL random_status op %h got %h cyc %0d want err=%0b cyc %0d", op, stat, cyc, err, ref_busy(op, b));
         end
      end
   endtask

   initial begin
      bus.address    = '0;
      bus.nRead      = 1'b1;
      bus.nWrite     = 1'b1;
      bus.ExeDataOut = '0;
      test_reset();
      test_add();
      test_sub_wrap();
      test_mul_max();
      test_div();
      test_select_and_map();
      test_read_write_same_edge();
      test_busy_and_abort();
      test_back_to_back();
      test_random_ops();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/integer_alu.md
INTEGER_ALU -- requirements
Module: integer_alu

Interface
REQ-001 The block SHALL have ports Clk, nReset, address, nRead, nWrite, ExeDataOut and IntDataOut, described in REQ-002..REQ-008.
REQ-002 Clk  input  1  system clock; all state SHALL update on posedge (execution engine drives bus on negedge).
REQ-003 nReset  input  1  reset, asynchronous, active-low.
REQ-004 address  input  16  [15:12] module enable, [11:0] register offset.
REQ-005 nRead  input  1  active-low read strobe.
REQ-006 nWrite  input  1  active-low write strobe.
REQ-007 ExeDataOut  input  256  write data from execution engine.
REQ-008 IntDataOut  output  256  read data to execution engine.
REQ-009 Parameter INT_ALU_EN, default 3, SHALL be the enable code that selects this block.
REQ-010 Parameter MUL_CYCLES, default 32, SHALL be the iteration count for multiply and divide.

Function
REQ-011 The block SHALL be selected only when address[15:12] == INT_ALU_EN.
REQ-012 Register map SHALL be: offset 0 = SRC1, 1 = SRC2, 2 = RESULT (read-only), 3 = write OPCODE / read STATUS; other offsets SHALL be ignored on write and read as 0.
REQ-013 A write SHALL occur on the posedge where the block is selected and nWrite == 0.
REQ-014 IntDataOut SHALL be combinational and SHALL equal the addressed register when selected with nRead == 0, else 0.
REQ-015 STATUS SHALL be bit0 busy, bit1 done, bit2 error; bits [255:3] SHALL be 0.
REQ-016 Opcodes SHALL be taken from OPCODE[7:0]: 0x10 ADD, 0x11 SUB, 0x12 AND, 0x13 OR, 0x14 MUL, 0x15 DIV.
REQ-017 ADD, SUB, AND and OR SHALL operate on the full 256 bits; ADD and SUB SHALL wrap modulo 2^256.
REQ-018 MUL SHALL compute the unsigned product of SRC1[31:0] and SRC2[31:0] into RESULT[63:0], with RESULT[255:64] = 0.
REQ-019 DIV SHALL be unsigned: quotient in RESULT[31:0], remainder in RESULT[63:32], rest 0.
REQ-020 The FSM SHALL have states IDLE, ITER and DONE.
REQ-021 From IDLE or DONE, an OPCODE write SHALL clear done and error; then:
- ADD, SUB, AND, OR: RESULT written on that same edge, next state DONE (latency 1).
- MUL, DIV: next state ITER, busy = 1, iteration counter loaded with 0.
REQ-022 ITER SHALL perform one shift-add (MUL) or restoring-subtract (DIV) step per cycle; after MUL_CYCLES steps it SHALL write RESULT, clear busy, set done and move to DONE (latency MUL_CYCLES + 1 from the OPCODE write).
REQ-023 DONE SHALL hold RESULT and done = 1 until the next OPCODE write.
REQ-024 An unknown opcode SHALL set error = 1 and done = 1, write RESULT = 0, and go to DONE.
REQ-025 DIV with SRC2[31:0] == 0 SHALL complete in 1 cycle with RESULT[63:0] all ones, error = 1, done = 1.
REQ-026 While busy, writes to any offset SHALL be ignored, and operands SHALL be latched internally at operation start.
REQ-027 When nRead and nWrite are both low on the same edge, the write SHALL take effect and read data SHALL reflect the pre-edge value.
REQ-028 A write to offset 2 SHALL be ignored.

Reset
REQ-029 While nReset == 0, SRC1, SRC2, RESULT, the opcode latch, the counter and the STATUS bits SHALL be 0 and the FSM SHALL be in IDLE, regardless of Clk.
REQ-030 Reset asserted during ITER SHALL abort the operation with no RESULT update.
REQ-031 IntDataOut SHALL be 0 during reset.

Structure
REQ-032 Shared package alu_pkg SHALL hold the module enable codes (MainMem 0 .. Execute 5), the register offsets, the opcode constants and the FSM state enum.
REQ-033 The iterative datapath SHALL be sub-module int_seq_muldiv, with start/mode/operands in and done/result out.

Verification
REQ-034 SRC1 = 5, SRC2 = 7, OPCODE = 0x10 -> the next cycle STATUS = 0x2 and RESULT = 12.
REQ-035 SRC1 = 0, SRC2 = 1, OPCODE = 0x11 -> RESULT = 2^256 - 1 (all ones).
REQ-036 SRC1 = 0xFFFFFFFF, SRC2 = 0xFFFFFFFF, OPCODE = 0x14 -> busy for 32 cycles, then RESULT = 0xFFFFFFFE00000001 and STATUS = 0x2.
REQ-037 SRC1 = 100, SRC2 = 7, OPCODE = 0x15 -> RESULT[31:0] = 14 and RESULT[63:32] = 2; the same with SRC2 = 0 -> STATUS = 0x6 and RESULT[63:0] all ones.
REQ-038 Start MUL, write SRC1 = 9 at cycle 5, pulse nReset at cycle 10 -> SRC1 unchanged by the cycle-5 write; all registers 0 after reset; a subsequent ADD still works.
REQ-039 address[15:12] = 2 with a write, and OPCODE = 0x7F -> no register change; STATUS = 0x6, RESULT = 0.
